// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and helpers for the push-button counters
//
// Purpose: debouncer state encoding and the count range helper, shared by
//          btn_debounce and increase_count.
// Contents: deb_state_t, count_max().

package count_pkg;

  // Debouncer states: a level is only accepted after it has been stable
  // through the matching *_WAIT state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // Largest legal count value for size exponent n.
  function automatic int unsigned count_max(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser plus debounce FSM for one button
//
// Purpose: turns a raw, bouncing, active-low button into a clean level and a
//          single-cycle strobe per confirmed press.
// Ports:
//   clk        system clock, rising edge
//   btn_reset  asynchronous active-low reset
//   btn_n      raw button, asynchronous to clk, 0 = pressed
//   press      one-clock strobe when a press is confirmed (registered)
//   level      debounced level, 1 = held (registered)

module btn_debounce
  import count_pkg::*;
#(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic btn_reset,
  input  logic btn_n,
  output logic press,
  output logic level
);

  // The counter never needs to hold more than DEB_CYCLES-2, so this width is
  // always sufficient (DEB_CYCLES >= 2).
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 2);

  logic          sync1;
  logic          sync2;
  deb_state_t    state;
  logic [CW-1:0] cnt;

  // Both stages reset to the released level so no false press is seen
  // while the synchroniser refills after reset.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // cnt holds (stable samples seen - 1) while in a *_WAIT state: the sample
  // that enters the wait state is the first of DEB_CYCLES, so the transition
  // fires on the sample where cnt already equals DEB_CYCLES-2.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      state <= IDLE;
      cnt   <= '0;
      press <= 1'b0;
      level <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (sync2) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
            state <= PRESSED;
            cnt   <= '0;
            press <= 1'b1;
            level <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to 0 resumes the held press without a new strobe.
          if (!sync2) begin
            state <= PRESSED;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/increase_count.sv
// rtl/increase_count.sv - debounced push-button up-counter with wrap pulse
//
// Purpose: counts confirmed presses of btn_increment modulo 2**N, with
//          btn_clear forcing the count back to zero.
// Ports:
//   clk            system clock, rising edge
//   btn_reset      asynchronous active-low reset
//   btn_increment  raw button, active-low
//   btn_clear      raw button, active-low
//   count          current count, 2**N bits wide, range 0 .. 2**N-1
//   wrap           one-cycle pulse on the 2**N-1 -> 0 increment
//   pressed        debounced level of btn_increment

module increase_count
  import count_pkg::*;
#(
  parameter int N          = 2,
  parameter int DEB_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            btn_reset,
  input  logic            btn_increment,
  input  logic            btn_clear,
  output logic [2**N-1:0] count,
  output logic            wrap,
  output logic            pressed
);

  localparam int W = 2**N;
  localparam logic [W-1:0] MAX = W'(count_max(N));

  logic inc_press;
  logic clr_press;
  logic clr_level_unused;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_inc_deb (
    .clk      (clk),
    .btn_reset(btn_reset),
    .btn_n    (btn_increment),
    .press    (inc_press),
    .level    (pressed)
  );

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_clr_deb (
    .clk      (clk),
    .btn_reset(btn_reset),
    .btn_n    (btn_clear),
    .press    (clr_press),
    .level    (clr_level_unused)
  );

  // Clear has priority; an increment in the same cycle is dropped.
  always_ff @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_press) begin
        count <= '0;
      end else if (inc_press) begin
        if (count == MAX) begin
          count <= '0;
          wrap  <= 1'b1;
        end else begin
          count <= count + W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_increase_count.sv
// tb/tb_increase_count.sv - self-checking bench for increase_count

module tb_increase_count;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int MAXC = (1 << N) - 1;

  logic              clk;
  logic              btn_reset;
  logic              btn_increment;
  logic              btn_clear;
  logic [2**N-1:0]   count;
  logic              wrap;
  logic              pressed;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  increase_count #(
    .N         (N),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .btn_reset    (btn_reset),
    .btn_increment(btn_increment),
    .btn_clear    (btn_clear),
    .count        (count),
    .wrap         (wrap),
    .pressed      (pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a button level is accepted once the synchronised input
  // has shown the opposite level for DEB consecutive clocks. Index 0 is
  // increment, 1 is clear.
  int count_m;
  int wrap_m;
  bit acc[2];
  int run[2];
  bit stb[2];
  bit dl0[2];
  bit dl1[2];

  task automatic model_reset();
    count_m = 0;
    wrap_m  = 0;
    for (int b = 0; b < 2; b++) begin
      acc[b] = 0;
      run[b] = 0;
      stb[b] = 0;
      dl0[b] = 1;
      dl1[b] = 1;
    end
  endtask

  task automatic model_step();
    bit raw[2];
    bit s;
    raw[0] = btn_increment;
    raw[1] = btn_clear;
    wrap_m = 0;
    if (stb[1]) begin
      count_m = 0;
    end else if (stb[0]) begin
      if (count_m == MAXC) begin
        count_m = 0;
        wrap_m  = 1;
      end else begin
        count_m = count_m + 1;
      end
    end
    for (int b = 0; b < 2; b++) begin
      s      = dl1[b];
      dl1[b] = dl0[b];
      dl0[b] = raw[b];
      stb[b] = 0;
      if (s == acc[b]) run[b] = run[b] + 1;
      else run[b] = 0;
      if (run[b] == DEB) begin
        acc[b] = !acc[b];
        run[b] = 0;
        if (acc[b]) stb[b] = 1;
      end
    end
  endtask

  always @(posedge clk or negedge btn_reset) begin
    if (!btn_reset) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", int'(count), count_m);
      check("wrap", int'(wrap), wrap_m);
      check("pressed", int'(pressed), int'(acc[0]));
    end
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit inc, input bit clr, input int hold, input int gap,
                       output int wraps);
    wraps = 0;
    btn_increment = !inc;
    btn_clear     = !clr;
    for (int i = 0; i < hold + gap; i++) begin
      if (i == hold) begin
        btn_increment = 1'b1;
        btn_clear     = 1'b1;
      end
      edge1();
      wraps += int'(wrap);
    end
  endtask

  int w;
  int exp_seq[4];
  int hi;
  int hc;

  initial begin
    btn_reset     = 1'b1;
    btn_increment = 1'b1;
    btn_clear     = 1'b1;

    // Asynchronous reset before any clock edge.
    #2 btn_reset = 1'b0;
    #1;
    check("reset_count", int'(count), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_pressed", int'(pressed), 0);
    @(negedge clk);
    @(negedge clk);
    btn_reset = 1'b1;
    chk_en = 1;
    edge1();

    // Single press: count becomes 1 on edge DEB+3 = 7.
    btn_increment = 1'b0;
    repeat (6) edge1();
    check("single_edge6_count", int'(count), 0);
    check("single_edge6_pressed", int'(pressed), 1);
    edge1();
    check("single_edge7_count", int'(count), 1);
    repeat (13) edge1();
    check("single_held_count", int'(count), 1);
    btn_increment = 1'b1;
    repeat (12) edge1();
    check("single_release_pressed", int'(pressed), 0);
    check("single_release_count", int'(count), 1);

    // Glitch shorter than DEB.
    press(1, 0, 3, 10, w);
    check("glitch_count", int'(count), 1);

    // Clear, then four presses wrap through 0.
    press(0, 1, 8, 12, w);
    check("clear_count", int'(count), 0);
    exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 3; exp_seq[3] = 0;
    for (int k = 0; k < 4; k++) begin
      press(1, 0, 8, 12, w);
      check($sformatf("wrap_step%0d_count", k), int'(count), exp_seq[k]);
      check($sformatf("wrap_step%0d_pulses", k), w, (k == 3) ? 1 : 0);
    end

    // Clear and increment together from count 2.
    press(1, 0, 8, 12, w);
    press(1, 0, 8, 12, w);
    check("both_pre_count", int'(count), 2);
    press(1, 1, 8, 12, w);
    check("both_count", int'(count), 0);
    check("both_wrap", w, 0);
    press(1, 0, 8, 12, w);
    check("both_after_inc", int'(count), 1);

    // Reset during the third PRESS_WAIT clock; button still held afterwards.
    btn_increment = 1'b0;
    repeat (5) edge1();
    btn_reset = 1'b0;
    #1;
    check("midreset_count", int'(count), 0);
    check("midreset_pressed", int'(pressed), 0);
    edge1();
    edge1();
    btn_reset = 1'b1;
    edge1();
    edge1();
    btn_increment = 1'b1;
    repeat (15) edge1();
    check("midreset_after_count", int'(count), 0);
    check("midreset_after_pressed", int'(pressed), 0);

    // Randomised button activity against the model.
    hi = 0;
    hc = 0;
    repeat (3000) begin
      if (hi == 0) begin
        btn_increment = ~btn_increment;
        hi = $urandom_range(1, 12);
      end
      if (hc == 0) begin
        if (btn_clear) btn_clear = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        else btn_clear = 1'b1;
        hc = $urandom_range(1, 12);
      end
      hi--;
      hc--;
      edge1();
    end
    btn_increment = 1'b1;
    btn_clear     = 1'b1;
    repeat (20) edge1();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
